iterative_alu: RTL and testbench



---
 rtl/iterative_alu_if.sv | 27 ++
 rtl/iterative_alu.sv | 172 +++++++++++++++++
 tb/tb_iterative_alu.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/iterative_alu_if.sv
// Handshake and operand/result bundle for iterative_alu.
//   master : request/response driver side (operands, in_valid, out_ready)
//   slave  : the ALU side (in_ready, out_valid, ALUResult, Zero, Busy)
interface iterative_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  Busy;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Busy
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Busy
  );
endinterface

// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle ALU behind a valid/ready handshake.
// Logic ops, ADD/SUB, EQ and SRL-by-0 finish one cycle after accept;
// SRL by a non-zero amount shifts SHIFT_STEP bits per cycle in SHIFT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : iterative_alu_if slave (in_valid/in_ready, Operation,
//                SrcA, SrcB, out_valid/out_ready, ALUResult, Zero, Busy)
module iterative_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic           clk,
  input logic           rst_n,
  iterative_alu_if.slave bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  // One extra bit so a step equal to DATA_WIDTH is representable.
  localparam int STW = SHW + 1;
  localparam logic [STW-1:0] STEP = STW'(SHIFT_STEP);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_EQ  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic [SHW-1:0]        remaining_q, remaining_d;

  logic                  accept_s;
  logic                  iter_shift_s;
  logic [SHW-1:0]        shamt_s;
  logic [STW-1:0]        step_s;
  logic                  shift_last_s;
  logic [DATA_WIDTH-1:0] op_res_s;

  assign accept_s     = bus.in_valid && (state_q == IDLE);
  assign shamt_s      = bus.SrcB[SHW-1:0];
  assign iter_shift_s = (bus.Operation == OP_SRL) && (shamt_s != {SHW{1'b0}});
  assign shift_last_s = ({1'b0, remaining_q} <= STEP);

  // Single-cycle result for every code; SRL here only covers shamt 0.
  always_comb begin
    op_res_s = {DATA_WIDTH{1'b0}};
    case (bus.Operation)
      OP_AND:  op_res_s = bus.SrcA & bus.SrcB;
      OP_OR:   op_res_s = bus.SrcA | bus.SrcB;
      OP_ADD:  op_res_s = bus.SrcA + bus.SrcB;
      OP_SUB:  op_res_s = bus.SrcA - bus.SrcB;
      OP_XOR:  op_res_s = bus.SrcA ^ bus.SrcB;
      OP_SRL:  op_res_s = bus.SrcA >> shamt_s;
      OP_EQ:   op_res_s = {{(DATA_WIDTH-1){1'b0}}, (bus.SrcA == bus.SrcB)};
      default: op_res_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Per-cycle shift amount: min(SHIFT_STEP, remaining).
  always_comb begin
    step_s = STEP;
    if ({1'b0, remaining_q} < STEP) begin
      step_s = {1'b0, remaining_q};
    end else begin
      step_s = STEP;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= {DATA_WIDTH{1'b0}};
      zero_q      <= 1'b1;
      remaining_q <= {SHW{1'b0}};
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = iter_shift_s ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shift_last_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; result_q doubles as the shift register.
  always_comb begin
    result_d    = result_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (accept_s && iter_shift_s) begin
          result_d    = bus.SrcA;
          remaining_d = shamt_s;
        end else if (accept_s) begin
          result_d    = op_res_s;
          remaining_d = {SHW{1'b0}};
        end else begin
          result_d    = result_q;
          remaining_d = remaining_q;
        end
      end
      SHIFT: begin
        result_d    = result_q >> step_s;
        // step_s never exceeds remaining_q, so the low bits suffice.
        remaining_d = remaining_q - step_s[SHW-1:0];
      end
      DONE: begin
        result_d    = result_q;
        remaining_d = remaining_q;
      end
      default: begin
        result_d    = {DATA_WIDTH{1'b0}};
        remaining_d = {SHW{1'b0}};
      end
    endcase
    // Zero tracks the value being registered, so it always matches ALUResult.
    zero_d = (result_d == {DATA_WIDTH{1'b0}});
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.Busy      = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      SHIFT:   bus.Busy      = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu. Two instances share the
// clock and reset: dut1 with SHIFT_STEP 1, dut4 with SHIFT_STEP 4.
module tb_iterative_alu;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  iterative_alu_if #(.DATA_WIDTH(32)) bus1 ();
  iterative_alu_if #(.DATA_WIDTH(32)) bus4 ();

  iterative_alu #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  iterative_alu #(.DATA_WIDTH(32), .SHIFT_STEP(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle op on dut1 with out_ready high: result one cycle after accept.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
    bus1.in_valid  = 1'b1;
    bus1.Operation = op;
    bus1.SrcA      = a;
    bus1.SrcB      = b;
    bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, bus1.out_valid}, 32'd1);
    check({tag, "_res"}, bus1.ALUResult, exp_res);
    check({tag, "_zero"}, {31'd0, bus1.Zero}, {31'd0, exp_zero});
    check({tag, "_inrdy_lo"}, {31'd0, bus1.in_ready}, 32'd0);
    tick();
    check({tag, "_inrdy_hi"}, {31'd0, bus1.in_ready}, 32'd1);
    check({tag, "_valid_lo"}, {31'd0, bus1.out_valid}, 32'd0);
  endtask

  int cyc;
  int busy_cnt;
  int seen;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus1.in_valid = 1'b0; bus1.Operation = 4'd0; bus1.SrcA = 32'd0; bus1.SrcB = 32'd0; bus1.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.Operation = 4'd0; bus4.SrcA = 32'd0; bus4.SrcB = 32'd0; bus4.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, bus1.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus1.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus1.Busy}, 32'd0);
    check("rst_result", bus1.ALUResult, 32'd0);
    check("rst_zero", {31'd0, bus1.Zero}, 32'd1);
    rst_n = 1'b1;
    tick();

    run_op("add", 4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1);
    run_op("sub", 4'b0011, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    run_op("or",  4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0);
    run_op("xor", 4'b0100, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0);
    run_op("and", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0);
    run_op("bad", 4'b0111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1);
    run_op("eq_t", 4'b1001, 32'd7, 32'd7, 32'd1, 1'b0);
    run_op("eq_f", 4'b1001, 32'd7, 32'd8, 32'd0, 1'b1);
    // shamt uses only SrcB[4:0]; 0x20 -> shamt 0 -> single-cycle path
    run_op("srl0", 4'b1000, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 1'b0);

    // SRL by 4 on SHIFT_STEP 1: Busy 4 cycles, out_valid at accept+5
    bus1.in_valid = 1'b1; bus1.Operation = 4'b1000;
    bus1.SrcA = 32'h8000_0000; bus1.SrcB = 32'hFFFF_FFE4; bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    bus1.SrcA = 32'hDEAD_BEEF;
    cyc = 1; busy_cnt = 0;
    while (!bus1.out_valid && cyc < 50) begin
      if (bus1.Busy) busy_cnt++;
      tick();
      cyc++;
    end
    check("srl4_latency", cyc, 32'd5);
    check("srl4_busy", busy_cnt, 32'd4);
    check("srl4_res", bus1.ALUResult, 32'h0800_0000);
    check("srl4_zero", {31'd0, bus1.Zero}, 32'd0);
    check("srl4_busy_done", {31'd0, bus1.Busy}, 32'd0);
    tick();
    check("srl4_inrdy", {31'd0, bus1.in_ready}, 32'd1);

    // SRL 0xFFFFFFFF by 31 on SHIFT_STEP 4: 8 SHIFT cycles
    bus4.in_valid = 1'b1; bus4.Operation = 4'b1000;
    bus4.SrcA = 32'hFFFF_FFFF; bus4.SrcB = 32'd31; bus4.out_ready = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!bus4.out_valid && cyc < 50) begin
      if (bus4.Busy) busy_cnt++;
      tick();
      cyc++;
    end
    check("srl31_latency", cyc, 32'd9);
    check("srl31_busy", busy_cnt, 32'd8);
    check("srl31_res", bus4.ALUResult, 32'h0000_0001);
    tick();
    check("srl31_valid_lo", {31'd0, bus4.out_valid}, 32'd0);

    // Stall in DONE with out_ready low while inputs wiggle
    bus1.in_valid = 1'b1; bus1.Operation = 4'b0010;
    bus1.SrcA = 32'd2; bus1.SrcB = 32'd3; bus1.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus1.in_valid = i[0];
      bus1.SrcA     = $urandom;
      bus1.Operation = 4'b0100;
      tick();
      check("stall_inrdy", {31'd0, bus1.in_ready}, 32'd0);
      check("stall_valid", {31'd0, bus1.out_valid}, 32'd1);
      check("stall_res", bus1.ALUResult, 32'd5);
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    tick();
    check("stall_rel_valid", {31'd0, bus1.out_valid}, 32'd0);
    check("stall_rel_inrdy", {31'd0, bus1.in_ready}, 32'd1);
    tick();
    check("stall_no_second", {31'd0, bus1.out_valid}, 32'd0);

    // Reset in the 2nd SHIFT cycle of a shamt-20 SRL
    bus1.in_valid = 1'b1; bus1.Operation = 4'b1000;
    bus1.SrcA = 32'hFFFF_0000; bus1.SrcB = 32'd20; bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    check("rstmid_busy_pre", {31'd0, bus1.Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, bus1.Busy}, 32'd0);
    check("rstmid_valid", {31'd0, bus1.out_valid}, 32'd0);
    check("rstmid_inrdy", {31'd0, bus1.in_ready}, 32'd1);
    check("rstmid_res", bus1.ALUResult, 32'd0);
    check("rstmid_zero", {31'd0, bus1.Zero}, 32'd1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus1.out_valid) seen++;
    end
    check("rstmid_no_result", seen, 32'd0);
    run_op("add_after_rst", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
